// File: rtl/equiv_pkg.sv
// Shared types and constants for the expression equivalence sweep checker.
package equiv_pkg;

  localparam int unsigned SETTLE_MAX = 15;
  localparam int unsigned SETTLE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that holds each test vector for a programmable number of cycles.
module settle_timer
  import equiv_pkg::*;
#(
  parameter int unsigned W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero_c
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/equiv_sweep_checker.sv
// Exhaustively sweeps all input vectors through two expression blocks and
// records how many vectors disagree plus the first disagreeing vector.
module equiv_sweep_checker
  import equiv_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] abc_out,
  input  logic            orig_in,
  input  logic            simp_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam int unsigned CW = N_IN + 1;
  localparam logic [N_IN-1:0]     VEC_LAST = '1;
  localparam logic [SETTLE_W-1:0] RELOAD   = SETTLE_W'(SETTLE - 1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] abc_q, abc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] ffvec_q, ffvec_d;
  logic            ffvalid_q, ffvalid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            tmr_load, tmr_tick, tmr_zero;

  settle_timer #(.W(SETTLE_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (RELOAD),
    .tick     (tmr_tick),
    .zero_c   (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      abc_q     <= '0;
      cnt_q     <= '0;
      ffvec_q   <= '0;
      ffvalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      abc_q     <= abc_d;
      cnt_q     <= cnt_d;
      ffvec_q   <= ffvec_d;
      ffvalid_q <= ffvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    abc_d     = abc_q;
    cnt_d     = cnt_q;
    ffvec_d   = ffvec_q;
    ffvalid_d = ffvalid_q;
    tmr_load  = 1'b0;
    tmr_tick  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_DRIVE;
          abc_d     = '0;
          cnt_d     = '0;
          ffvec_d   = '0;
          ffvalid_d = 1'b0;
          tmr_load  = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (tmr_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          tmr_tick = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (orig_in ^ simp_in) begin
          cnt_d = cnt_q + CW'(1);
          if (!ffvalid_q) begin
            ffvec_d   = abc_q;
            ffvalid_d = 1'b1;
          end
        end
        // Last vector stops here so abc_out holds instead of wrapping.
        if (abc_q == VEC_LAST) begin
          state_d = ST_DONE;
        end else begin
          abc_d    = abc_q + N_IN'(1);
          tmr_load = 1'b1;
          state_d  = ST_DRIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (cnt_d == '0);
  end

  assign abc_out          = abc_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_count   = cnt_q;
  assign first_fail_vec   = ffvec_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_equiv_sweep_checker.sv
// Self-checking bench: two checkers (SETTLE=1 and SETTLE=3) sweep truth-table driven expressions.
module tb_equiv_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] orig_tt, simp_tt;

  logic [2:0] abc1, ffv1, abc3, ffv3;
  logic [3:0] cnt1, cnt3;
  logic       busy1, done1, pass1, ffok1, orig1, simp1;
  logic       busy3, done3, pass3, ffok3, orig3, simp3;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_cnt;
  int exp_first;

  always #5 clk = ~clk;

  assign orig1 = orig_tt[abc1];
  assign simp1 = simp_tt[abc1];
  assign orig3 = orig_tt[abc3];
  assign simp3 = simp_tt[abc3];

  equiv_sweep_checker #(.N_IN(3), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abc_out(abc1),
    .orig_in(orig1), .simp_in(simp1), .busy(busy1), .done(done1), .pass(pass1),
    .mismatch_count(cnt1), .first_fail_vec(ffv1), .first_fail_valid(ffok1)
  );

  equiv_sweep_checker #(.N_IN(3), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abc_out(abc3),
    .orig_in(orig3), .simp_in(simp3), .busy(busy3), .done(done3), .pass(pass3),
    .mismatch_count(cnt3), .first_fail_vec(ffv3), .first_fail_valid(ffok3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected results straight from the truth tables: count and lowest differing vector.
  task automatic model();
    exp_cnt   = 0;
    exp_first = -1;
    for (int v = 0; v < 8; v++) begin
      if (orig_tt[v] != simp_tt[v]) begin
        exp_cnt++;
        if (exp_first < 0) exp_first = v;
      end
    end
  endtask

  task automatic check_all_reset();
    chk("rst_abc1", 32'(abc1), 0);   chk("rst_abc3", 32'(abc3), 0);
    chk("rst_busy1", 32'(busy1), 0); chk("rst_busy3", 32'(busy3), 0);
    chk("rst_done1", 32'(done1), 0); chk("rst_done3", 32'(done3), 0);
    chk("rst_pass1", 32'(pass1), 0); chk("rst_pass3", 32'(pass3), 0);
    chk("rst_cnt1", 32'(cnt1), 0);   chk("rst_cnt3", 32'(cnt3), 0);
    chk("rst_ffv1", 32'(ffv1), 0);   chk("rst_ffv3", 32'(ffv3), 0);
    chk("rst_ffok1", 32'(ffok1), 0); chk("rst_ffok3", 32'(ffok3), 0);
  endtask

  // Expected per-cycle behaviour of one checker, c cycles after the accept edge.
  task automatic check_dut(input string nm, input int c, input int per,
                           input logic [2:0] abc, input logic busy, input logic done,
                           input logic pass, input logic [3:0] cnt,
                           input logic [2:0] ffv, input logic ffok);
    int lat;
    lat = 8 * per;
    if (c < lat) begin
      chk({nm, "_abc"}, 32'(abc), 32'(c / per));
      chk({nm, "_busy"}, 32'(busy), 1);
      chk({nm, "_done"}, 32'(done), 0);
      chk({nm, "_pass"}, 32'(pass), 0);
    end else begin
      chk({nm, "_abc_hold"}, 32'(abc), 7);
      chk({nm, "_busy_end"}, 32'(busy), 0);
      chk({nm, "_done_end"}, 32'(done), 1);
      chk({nm, "_pass_end"}, 32'(pass), 32'(exp_cnt == 0));
      chk({nm, "_count"}, 32'(cnt), 32'(exp_cnt));
      chk({nm, "_ffok"}, 32'(ffok), 32'(exp_cnt != 0));
      if (exp_cnt != 0) chk({nm, "_ffvec"}, 32'(ffv), 32'(exp_first));
    end
  endtask

  // Caller guarantees clk is low; the next rising edge accepts start.
  task automatic sweep(input bit hold, input int c_stop);
    model();
    start = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= c_stop; c++) begin
      @(negedge clk);
      if (hold && c >= 17) begin
        chk("hold_abc1", 32'(abc1), 32'((c - 17) / 2));
        chk("hold_busy1", 32'(busy1), 1);
        chk("hold_done1", 32'(done1), 0);
        if (c == 17) begin
          chk("restart_cnt1", 32'(cnt1), 0);
          chk("restart_ffok1", 32'(ffok1), 0);
          chk("restart_pass1", 32'(pass1), 0);
        end
      end else begin
        check_dut("d1", c, 2, abc1, busy1, done1, pass1, cnt1, ffv1, ffok1);
      end
      check_dut("d3", c, 4, abc3, busy3, done3, pass3, cnt3, ffv3, ffok3);
      if (!hold || c == 17) start = 1'b0;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    orig_tt = 8'h00;
    simp_tt = 8'h00;
    repeat (3) @(negedge clk);
    check_all_reset();
    rst_n = 1'b1;

    // Identical expressions
    orig_tt = 8'($urandom);
    simp_tt = orig_tt;
    sweep(1'b0, 33);

    // Differ only at vector 101
    orig_tt = 8'($urandom);
    simp_tt = orig_tt ^ 8'b0010_0000;
    sweep(1'b0, 33);

    // Complementary expressions
    orig_tt = 8'($urandom);
    simp_tt = ~orig_tt;
    sweep(1'b0, 33);

    // Random pairs
    for (int k = 0; k < 4; k++) begin
      orig_tt = 8'($urandom);
      simp_tt = 8'($urandom);
      sweep(1'b0, 33);
    end

    // start held: no mid-sweep restart, restart from DONE; then reset at vector 4
    orig_tt = 8'($urandom);
    simp_tt = 8'($urandom);
    sweep(1'b1, 25);
    chk("pre_rst_abc1", 32'(abc1), 4);
    #2 rst_n = 1'b0;
    #1 check_all_reset();
    rst_n = 1'b1;

    // Clean sweep right after reset release
    orig_tt = 8'($urandom);
    simp_tt = 8'($urandom);
    sweep(1'b0, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
